// File: rtl/line_mirror_pkg.sv
// line_mirror_pkg: shared FSM state type and address-width helper for line_mirror.
package line_mirror_pkg;
  typedef enum logic {EMPTY, STREAM} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/mirror_bank_ram.sv
// mirror_bank_ram: simple dual-port line bank with 1-cycle registered read; read data holds when idle.
module mirror_bank_ram #(
  parameter int W = 36,
  parameter int D = 640,
  parameter int AW = 10
)(
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_q
);
  logic [W-1:0] r_mem [D];
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_q <= r_mem[i_raddr];
  end
endmodule

// File: rtl/line_mirror.sv
// line_mirror: ping-pong line buffer emitting each line horizontally flipped, one line plus one cycle late.
// Define LINE_MIRROR_BYPASS_EN to add iMIRROR (per-line choice of flip or straight order).
module line_mirror
  import line_mirror_pkg::*;
#(
  parameter int PIX_W  = 12,
  parameter int N_CH   = 3,
  parameter int LINE_W = 640
)(
  input  logic                   iCCD_PIXCLK,
  input  logic                   iRST,
  input  logic [N_CH*PIX_W-1:0]  iDATA,
  input  logic                   iDVAL,
`ifdef LINE_MIRROR_BYPASS_EN
  input  logic                   iMIRROR,
`endif
  output logic [N_CH*PIX_W-1:0]  oDATA,
  output logic                   oDVAL,
  output logic                   oPRIMED
);
  localparam int W  = N_CH * PIX_W;
  localparam int AW = clog2(LINE_W);
  localparam logic [AW-1:0] LAST = AW'(LINE_W - 1);
  state_t        r_state;
  logic [AW-1:0] r_wcnt;
  logic          r_wbank, r_mir, r_rsel, r_have;
  logic          w_mir_in, w_mir, w_last, w_rd;
  logic [AW-1:0] w_raddr;
  logic [W-1:0]  w_q [2];
`ifdef LINE_MIRROR_BYPASS_EN
  assign w_mir_in = iMIRROR;
`else
  assign w_mir_in = 1'b1;
`endif
  // mode is taken live on pixel 0 and frozen for the rest of the line
  assign w_mir   = (r_wcnt == '0) ? w_mir_in : r_mir;
  assign w_last  = iDVAL && (r_wcnt == LAST);
  assign w_rd    = iDVAL && (r_state == STREAM);
  assign w_raddr = w_mir ? LAST - r_wcnt : r_wcnt;
  always_ff @(posedge iCCD_PIXCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= EMPTY;
      r_wcnt  <= '0;
      r_wbank <= 1'b0;
      r_mir   <= 1'b1;
      r_rsel  <= 1'b0;
      r_have  <= 1'b0;
      oDVAL   <= 1'b0;
      oPRIMED <= 1'b0;
    end else begin
      if (iDVAL) begin
        r_wcnt <= w_last ? '0 : r_wcnt + AW'(1);
        if (r_wcnt == '0) r_mir <= w_mir_in;
      end
      if (w_last) begin
        r_wbank <= ~r_wbank;
        r_state <= STREAM;
        oPRIMED <= 1'b1;
      end
      oDVAL <= w_rd;
      if (w_rd) begin
        r_rsel <= ~r_wbank;
        r_have <= 1'b1;
      end
    end
  end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    mirror_bank_ram #(.W(W), .D(LINE_W), .AW(AW)) u_ram (
      .i_clk   (iCCD_PIXCLK),
      .i_we    (iDVAL && (r_wbank == 1'(b))),
      .i_waddr (r_wcnt),
      .i_wdata (iDATA),
      .i_re    (w_rd && (r_wbank != 1'(b))),
      .i_raddr (w_raddr),
      .o_q     (w_q[b])
    );
  end
  // RAM read ports hold between reads, so the muxed word holds while oDVAL is low
  assign oDATA = r_have ? w_q[r_rsel] : '0;
endmodule

// File: tb/tb_line_mirror.sv
// tb_line_mirror: scoreboard bench for an 8-pixel and a default 640-pixel line_mirror.
module tb_line_mirror;
`ifdef LINE_MIRROR_BYPASS_EN
  localparam bit MIR_EN = 1'b1;
`else
  localparam bit MIR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, dv0, dv1, mi0;
  logic [35:0] d0, d1, od0, od1;
  logic ov0, ov1, op0, op1;
  logic [35:0] prev [2][640];
  logic [35:0] cur [2][640];
  logic [35:0] last [2];
  int wc [2];
  bit primed [2];
  bit mir [2];
  int lw [2] = '{8, 640};
  logic [35:0] sb0 [$];
  logic [35:0] sb1 [$];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  line_mirror #(.PIX_W(12), .N_CH(3), .LINE_W(8)) u_dut8 (
    .iCCD_PIXCLK(clk), .iRST(rst), .iDATA(d0), .iDVAL(dv0),
`ifdef LINE_MIRROR_BYPASS_EN
    .iMIRROR(mi0),
`endif
    .oDATA(od0), .oDVAL(ov0), .oPRIMED(op0));

  line_mirror u_dut640 (
    .iCCD_PIXCLK(clk), .iRST(rst), .iDATA(d1), .iDVAL(dv1),
`ifdef LINE_MIRROR_BYPASS_EN
    .iMIRROR(1'b1),
`endif
    .oDATA(od1), .oDVAL(ov1), .oPRIMED(op1));

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [35:0] pix(input int v);
    logic [11:0] c;
    c = v[11:0];
    return {c, c, c};
  endfunction

  task automatic model_rst();
    for (int s = 0; s < 2; s++) begin
      wc[s] = 0;
      primed[s] = 1'b0;
      mir[s] = 1'b1;
      last[s] = '0;
    end
    sb0.delete();
    sb1.delete();
  endtask

  task automatic step(input int s, input bit v, input logic [35:0] d, input bit m);
    bit exp_v;
    logic [35:0] e;
    if (s == 0) begin dv0 = v; d0 = d; mi0 = m; end
    else begin dv1 = v; d1 = d; end
    exp_v = 1'b0;
    if (v) begin
      if (wc[s] == 0) mir[s] = MIR_EN ? m : 1'b1;
      if (primed[s]) begin
        e = prev[s][mir[s] ? lw[s] - 1 - wc[s] : wc[s]];
        if (s == 0) sb0.push_back(e); else sb1.push_back(e);
        exp_v = 1'b1;
      end
      cur[s][wc[s]] = d;
      if (wc[s] == lw[s] - 1) begin
        wc[s] = 0;
        for (int i = 0; i < lw[s]; i++) prev[s][i] = cur[s][i];
        primed[s] = 1'b1;
      end else wc[s]++;
    end
    @(posedge clk);
    #1;
    chk(s == 0 ? "dval8" : "dval640", 36'(s == 0 ? ov0 : ov1), 36'(exp_v));
    if (exp_v) begin
      e = (s == 0) ? sb0.pop_front() : sb1.pop_front();
      chk(s == 0 ? "data8" : "data640", s == 0 ? od0 : od1, e);
      last[s] = e;
    end else chk(s == 0 ? "hold8" : "hold640", s == 0 ? od0 : od1, last[s]);
    chk(s == 0 ? "primed8" : "primed640", 36'(s == 0 ? op0 : op1), 36'(primed[s]));
  endtask

  initial begin
    rst = 1'b1; dv0 = 1'b0; dv1 = 1'b0; d0 = '0; d1 = '0; mi0 = 1'b1;
    model_rst();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dval8", 36'(ov0), 36'(0));
    chk("rst_primed8", 36'(op0), 36'(0));
    chk("rst_data8", od0, '0);
    chk("rst_dval640", 36'(ov1), 36'(0));
    chk("rst_primed640", 36'(op1), 36'(0));
    chk("rst_data640", od1, '0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) step(0, 1'b1, pix(k), 1'b1);
    for (int k = 0; k < 8; k++) step(0, 1'b1, pix(8 + k), 1'b1);
    // gapped line, mode request dropped mid-line
    for (int k = 0; k < 8; k++) begin
      step(0, 1'b1, pix(16 + k), k < 3);
      step(0, 1'b0, 36'hdead_beef, k < 3);
    end
    for (int k = 0; k < 8; k++) step(0, 1'b1, pix(24 + k), 1'b0);
    for (int k = 0; k < 4; k++) step(0, 1'b1, pix(32 + k), 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_dval8", 36'(ov0), 36'(0));
    chk("arst_primed8", 36'(op0), 36'(0));
    chk("arst_data8", od0, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_rst();
    for (int k = 0; k < 8; k++) step(0, 1'b1, 36'($urandom), 1'b1);
    for (int k = 0; k < 8; k++) step(0, 1'b1, pix(48 + k), 1'b1);
    for (int k = 0; k < 3; k++) step(0, 1'b0, '0, 1'b1);
    dv0 = 1'b0;
    for (int l = 0; l < 2; l++)
      for (int k = 0; k < 640; k++) step(1, 1'b1, pix(k), 1'b1);
    step(1, 1'b0, '0, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
